// File: rtl/screensaver_sequencer.sv
// -----------------------------------------------------------------------------
// screensaver_sequencer
//
// Run-time scheduler for the screensaver image sources. Each source is started,
// given time to report ready, shown for a fixed number of whole frames, followed
// by an optional run of black frames, and then the next source is selected.
// Every visible change happens on a frame boundary derived from vsync.
//
// Optional feature (compile-time macro SEQ_TIMEOUT_EN):
//   defined   - a source that stays not-ready for TIMEOUT_FRAMES frame ticks
//               while waiting is skipped and timeout_err pulses once.
//   undefined - waiting is unbounded and timeout_err is tied low.
//
// Parameters:
//   NUM_SRC        number of image sources (>= 1); sel wraps NUM_SRC-1 -> 0
//   DWELL_FRAMES   whole frames each source stays visible (>= 1)
//   BLANK_FRAMES   whole black frames between sources (0 = no blank phase)
//   TIMEOUT_FRAMES frames to wait for gen_ready before skipping (>= 1)
//
// Ports:
//   clk          system / pixel clock
//   rst          asynchronous reset, active low
//   vsync        active-low vertical sync, synchronous to clk
//   gen_ready    per-source ready level (bit i = source i can display)
//   next         single-cycle manual advance request (honoured while showing)
//   hold         level; freezes the dwell count while high
//   sel          index of the active source, drives the pixel mux
//   gen_start    one-hot single-cycle start pulse to the selected source
//   blank        high = pixel mux forces r/g/b to 0
//   frame_tick   one-cycle pulse per frame boundary (vsync falling edge)
//   timeout_err  one-cycle pulse when a source is skipped
// -----------------------------------------------------------------------------
module screensaver_sequencer #(
    parameter int NUM_SRC        = 2,
    parameter int DWELL_FRAMES   = 8,
    parameter int BLANK_FRAMES   = 1,
    parameter int TIMEOUT_FRAMES = 4,
    localparam int SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic [NUM_SRC-1:0] gen_ready,
    input  logic               next,
    input  logic               hold,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] gen_start,
    output logic               blank,
    output logic               frame_tick,
    output logic               timeout_err
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // One shared frame counter serves the dwell, blank and timeout phases, so it
    // is sized for the largest of the three limits.
    localparam int MAX_DB     = (DWELL_FRAMES > BLANK_FRAMES) ? DWELL_FRAMES : BLANK_FRAMES;
    localparam int MAX_FRAMES = (MAX_DB > TIMEOUT_FRAMES) ? MAX_DB : TIMEOUT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    // With no blank phase the BLANK state is unreachable; keep the constant legal.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
`ifdef SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
`endif
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        LAUNCH = 2'd0,   // issue gen_start to the selected source
        WAIT   = 2'd1,   // blanked, waiting for a frame tick with the source ready
        SHOW   = 2'd2,   // source visible, counting dwell frames
        BLANK  = 2'd3    // black frames before the next source
    } state_t;

    state_t             state,     state_nxt;
    logic [CNT_W-1:0]   cnt,       cnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [NUM_SRC-1:0] gen_start_nxt;
    logic               blank_nxt;
    logic               next_pend, next_pend_nxt;
    logic               vsync_q;

    // Index of the source after the current one, wrapping to 0.
    logic [SEL_W-1:0]   sel_wrap;
    // One-hot decode of the current selection for the start pulse.
    logic [NUM_SRC-1:0] sel_onehot;

    assign sel_wrap = (sel == SEL_LAST) ? '0 : sel + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_onehot[i] = (sel == SEL_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Frame boundary detection
    // -------------------------------------------------------------------------
    // frame_tick is registered: it is high for the cycle after the first clock
    // edge that samples vsync low, and all frame counting uses this registered
    // copy. vsync_q resets high so a low vsync at reset release still produces
    // exactly one tick.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync_q & ~vsync;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    logic timeout_nxt;
`endif

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sel_nxt       = sel;
        next_pend_nxt = next_pend;
        gen_start_nxt = '0;
`ifdef SEQ_TIMEOUT_EN
        timeout_nxt   = 1'b0;
`endif

        case (state)
            LAUNCH: begin
                gen_start_nxt = sel_onehot;
                state_nxt     = WAIT;
                cnt_nxt       = '0;
            end

            WAIT: begin
                // Only a frame boundary can release the wait, so the picture
                // never switches part-way through a frame.
                if (frame_tick) begin
                    if (gen_ready[sel]) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        timeout_nxt = 1'b1;
                        sel_nxt     = sel_wrap;
                        state_nxt   = LAUNCH;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
`endif
                end
            end

            SHOW: begin
                // A pending manual advance exits on the next tick regardless of
                // hold and the dwell count; it coincides with dwell expiry as a
                // single advance. gen_ready is deliberately not looked at here.
                if (frame_tick && (next_pend || (!hold && cnt == DWELL_LAST))) begin
                    next_pend_nxt = 1'b0;
                    cnt_nxt       = '0;
                    if (BLANK_FRAMES == 0) begin
                        sel_nxt   = sel_wrap;
                        state_nxt = LAUNCH;
                    end else begin
                        state_nxt = BLANK;
                    end
                end else begin
                    if (next) begin
                        next_pend_nxt = 1'b1;
                    end
                    if (frame_tick && !hold) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            BLANK: begin
                if (frame_tick) begin
                    if (cnt == BLANK_LAST) begin
                        sel_nxt       = sel_wrap;
                        next_pend_nxt = 1'b0;
                        state_nxt     = LAUNCH;
                        cnt_nxt       = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = LAUNCH;
                cnt_nxt   = '0;
            end
        endcase

        // blank follows the state being entered, so it only moves together with
        // a state change (frame aligned apart from LAUNCH->WAIT, both blanked).
        blank_nxt = (state_nxt != SHOW);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LAUNCH;
            cnt       <= '0;
            sel       <= '0;
            next_pend <= 1'b0;
            gen_start <= '0;
            blank     <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            next_pend <= next_pend_nxt;
            gen_start <= gen_start_nxt;
            blank     <= blank_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/screensaver_sequencer.md
Name: screensaver_sequencer

Overview:
Run-time scheduler for the screensaver image sources (checkerboard, fractal, ...).
- Replaces the compile-time image select with a frame-aligned sequence: start a source, wait for it to report ready, show it for a fixed number of frames, blank, advance to the next source.
- Sits between the VGA timing generator (consumes vsync) and the per-source generators and output pixel mux (drives sel, gen_start, blank).

Parameters:
NUM_SRC, 2, number of image sources; sel wraps from NUM_SRC-1 to 0; must be >= 1.
DWELL_FRAMES, 8, full frames each source stays visible; must be >= 1.
BLANK_FRAMES, 1, full black frames between sources; 0 = no blank phase.
TIMEOUT_FRAMES, 4, frames to wait for gen_ready before skipping (optional feature only); must be >= 1.

Ports:
clk  input  1  system/pixel clock.
rst  input  1  reset; asynchronous, active-low.
vsync  input  1  active-low vertical sync from the VGA timing block, synchronous to clk.
gen_ready  input  NUM_SRC  per-source ready level; bit i high = source i can display.
next  input  1  single-cycle manual advance request.
hold  input  1  level; freezes the dwell count while high.
sel  output  max(1,$clog2(NUM_SRC))  index of the active source; drives the pixel mux.
gen_start  output  NUM_SRC  one-hot, single-cycle start pulse to the selected source.
blank  output  1  high = pixel mux forces r/g/b to 0.
frame_tick  output  1  one-cycle pulse per frame boundary.
timeout_err  output  1  one-cycle pulse when a source is skipped; tied 0 without the feature.

Behaviour:
- Reset (rst low, asynchronous): state=LAUNCH, sel=0, gen_start=0, blank=1, frame_tick=0, timeout_err=0, vsync_q=1, cnt=0, next_pend=0. Takes effect immediately, including mid-sequence.
- Frame tick:
  - vsync_q <= vsync.
  - frame_tick <= vsync_q & ~vsync, i.e. high for exactly one cycle, the cycle after the first clk edge that samples vsync low.
  - All frame counting uses this registered frame_tick.
- Counter: single cnt, width $clog2(max(DWELL_FRAMES,BLANK_FRAMES,TIMEOUT_FRAMES)+1). Cleared on every state entry.
- Output registers: all outputs are registered.
- LAUNCH:
  - gen_start <= one-hot(sel) for one cycle; next state WAIT. blank=1.
- WAIT:
  - blank=1.
  - Leave on the first frame_tick with gen_ready[sel]=1, going to SHOW. The switch is frame-aligned and never mid-frame.
  - gen_ready high without a frame_tick: keep waiting.
- SHOW:
  - blank=0.
  - Each frame_tick with hold=0 increments cnt.
  - On the frame_tick where cnt==DWELL_FRAMES-1 (hold=0): go to BLANK, or if BLANK_FRAMES==0 advance sel and go to LAUNCH.
  - next sets next_pend. The next frame_tick then exits exactly as for dwell expiry, regardless of hold and cnt.
  - next and dwell expiry on the same tick: one advance only.
  - A gen_ready drop during SHOW is ignored.
- BLANK:
  - blank=1; each frame_tick increments cnt.
  - On the tick where cnt==BLANK_FRAMES-1: sel <= (sel==NUM_SRC-1) ? 0 : sel+1; clear next_pend; go to LAUNCH.
- next in LAUNCH/WAIT/BLANK: ignored, not latched.
- NUM_SRC==1: sel stays 0; the sequence still runs (relaunches the same source).
- blank changes only on state transitions, which are frame-aligned except LAUNCH->WAIT (already blanked).

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT, cnt counts frame_ticks with gen_ready[sel]=0.
  - On the tick where cnt==TIMEOUT_FRAMES-1 and gen_ready[sel]=0: timeout_err pulses one cycle, sel advances (wrap), state goes to LAUNCH.
  - A ready source on that same tick wins and goes to SHOW (no error).
- Undefined: WAIT waits indefinitely; timeout_err is constant 0; no timeout logic is synthesized.

Test Plan:
1. Defaults, gen_ready=2'b11; release rst -> gen_start=2'b01 for one cycle; blank stays 1 until the 1st frame_tick, then 0 with sel=0.
2. Continue -> 8 visible frames at sel=0, then 1 blank frame, then gen_start=2'b10 and sel=1. After sel=1 dwell + blank: sel wraps to 0.
3. Pulse next mid-frame 2 of SHOW with hold=1 -> blank rises at the next frame_tick (frame 3). A second next in BLANK causes no extra advance.
4. gen_ready=2'b01 with sel=1 in WAIT -> blank held 1 for 20 frames, no sel change; raise gen_ready[1] -> SHOW on the following frame_tick.
5. With SEQ_TIMEOUT_EN, gen_ready=2'b01, sel=1 -> timeout_err pulses on the 4th frame_tick; sel=0; gen_start=2'b01 next cycle.
6. Assert rst for 3 cycles mid-SHOW at sel=1 -> outputs go to reset values immediately (sel=0, blank=1, gen_start=0). After release, scenario 1 repeats.
